// File: rtl/fp_fixed_convert_pipe.sv
// fp_fixed_convert_pipe: 3-stage bidirectional IEEE-754 single <-> signed Q(INT_W.FRAC_W)
// converter with valid/ready flow control on both sides.
// Build option: define CONV_ROUND_EN for round-to-nearest-even on dropped bits
// (default build truncates toward zero). Latency is the same in both builds.
module fp_fixed_convert_pipe #(
  parameter int INT_W  = 8,
  parameter int FRAC_W = 13
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_mode,
  output logic [31:0] out_data,
  output logic        out_ovf
);

  localparam int W = INT_W + FRAC_W;
  localparam logic [31:0] MAX_POS = 32'((64'd1 << (W - 1)) - 64'd1);
  localparam logic [31:0] MIN_NEG = ~MAX_POS;
  localparam logic [32:0] LIM     = 33'd1 << (W - 1);

`ifdef CONV_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  typedef enum logic [1:0] {K_NORM, K_ZERO, K_SAT, K_NAN} kind_e;

  logic        s1_valid_q, s1_valid_d, s1_mode_q, s1_mode_d, s1_sign_q, s1_sign_d;
  kind_e       s1_kind_q, s1_kind_d;
  logic [31:0] s1_sig_q, s1_sig_d;   // F2X: 1.m as 24-bit integer; X2F: |x|
  logic [5:0]  s1_sh_q, s1_sh_d;     // F2X: left shift placing binary point at bit 32; X2F: leading-one index
  logic        s2_valid_q, s2_valid_d, s2_mode_q, s2_mode_d, s2_sign_q, s2_sign_d;
  kind_e       s2_kind_q, s2_kind_d;
  logic [63:0] s2_ext_q, s2_ext_d;   // F2X: |value|*2^(FRAC_W+32); X2F: leading one at bit 63
  logic [7:0]  s2_exp_q, s2_exp_d;
  logic        out_valid_q, out_valid_d, out_mode_q, out_mode_d, out_ovf_q, out_ovf_d;
  logic [31:0] out_data_q, out_data_d;
  logic        s1_load, s2_load, s3_load;

  // Stage load enables: a stage loads when empty or when its contents move on
  always_comb begin
    s3_load = !out_valid_q || out_ready;
    s2_load = !s2_valid_q || s3_load;
    s1_load = !s1_valid_q || s2_load;
  end

  assign in_ready  = s1_load;
  assign out_valid = out_valid_q;
  assign out_mode  = out_mode_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

  // S1: classify/unpack the float, or take |x| and find its leading one
  always_comb begin : s1_comb
    logic [7:0]   f_exp;
    int           e_i;
    logic [W-1:0] x_in;
    logic [W-1:0] x_mag;
    logic [4:0]   lod;
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_sign_d  = s1_sign_q;
    s1_kind_d  = s1_kind_q;
    s1_sig_d   = s1_sig_q;
    s1_sh_d    = s1_sh_q;
    f_exp = in_data[30:23];
    e_i   = int'(f_exp) - 127;
    x_in  = in_data[W-1:0];
    x_mag = x_in[W-1] ? (~x_in + W'(1)) : x_in;
    lod   = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (x_mag[i]) lod = 5'(i);
    end
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_mode_d = in_mode;
        if (!in_mode) begin
          s1_sign_d = in_data[31];
          s1_sig_d  = {8'h00, 1'b1, in_data[22:0]};
          s1_sh_d   = '0;
          if (f_exp == 8'hFF)
            s1_kind_d = (in_data[22:0] == '0) ? K_SAT : K_NAN;
          else if (f_exp == 8'h00 || e_i < -FRAC_W - 1)
            s1_kind_d = K_ZERO;
          else if (e_i > INT_W - 1)
            s1_kind_d = K_SAT;
          else begin
            // e = INT_W-1 still goes through the shifter so -2^(INT_W-1) stays exact
            s1_kind_d = K_NORM;
            s1_sh_d   = 6'(e_i + FRAC_W + 9);
          end
        end else begin
          s1_sign_d = x_in[W-1];
          s1_sig_d  = 32'(x_mag);
          s1_sh_d   = {1'b0, lod};
          s1_kind_d = (x_mag == '0) ? K_ZERO : K_NORM;
        end
      end
    end
  end

  // S2: barrel shift into a wide frame keeping all dropped bits for rounding
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_mode_d  = s2_mode_q;
    s2_sign_d  = s2_sign_q;
    s2_kind_d  = s2_kind_q;
    s2_ext_d   = s2_ext_q;
    s2_exp_d   = s2_exp_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_mode_d = s1_mode_q;
        s2_sign_d = s1_sign_q;
        s2_kind_d = s1_kind_q;
        if (!s1_mode_q) begin
          s2_ext_d = {32'h0, s1_sig_q} << s1_sh_q;
          s2_exp_d = '0;
        end else begin
          s2_ext_d = {s1_sig_q << (5'd31 - s1_sh_q[4:0]), 32'h0};
          s2_exp_d = 8'(127 + int'(s1_sh_q) - FRAC_W);
        end
      end
    end
  end

  // S3: round, saturate/negate or pack into the output register; held while stalled
  always_comb begin : s3_comb
    logic        inc_f, inc_x;
    logic [32:0] mag_r;
    logic [23:0] mant_r;
    out_valid_d = out_valid_q;
    out_mode_d  = out_mode_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    inc_f  = ROUND_EN & s2_ext_q[31] & ((|s2_ext_q[30:0]) | s2_ext_q[32]);
    inc_x  = ROUND_EN & s2_ext_q[39] & ((|s2_ext_q[38:0]) | s2_ext_q[40]);
    mag_r  = {1'b0, s2_ext_q[63:32]} + 33'(inc_f);
    mant_r = {1'b0, s2_ext_q[62:40]} + 24'(inc_x);
    if (s3_load) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        out_mode_d = s2_mode_q;
        out_ovf_d  = 1'b0;
        out_data_d = '0;
        if (!s2_mode_q) begin
          case (s2_kind_q)
            K_ZERO: out_data_d = '0;
            K_NAN:  out_ovf_d  = 1'b1;
            K_SAT: begin
              out_data_d = s2_sign_q ? MIN_NEG : MAX_POS;
              out_ovf_d  = 1'b1;
            end
            default: begin
              if (!s2_sign_q && mag_r >= LIM) begin
                out_data_d = MAX_POS;
                out_ovf_d  = 1'b1;
              end else if (s2_sign_q && mag_r > LIM) begin
                out_data_d = MIN_NEG;
                out_ovf_d  = 1'b1;
              end else begin
                out_data_d = s2_sign_q ? (~mag_r[31:0] + 32'd1) : mag_r[31:0];
              end
            end
          endcase
        end else if (s2_kind_q != K_ZERO) begin
          out_data_d = {s2_sign_q, s2_exp_q + 8'(mant_r[23]), mant_r[22:0]};
        end
      end
    end
  end

  // Pipeline registers; async reset empties every stage at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_kind_q   <= K_NORM;
      s1_sig_q    <= '0;
      s1_sh_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_mode_q   <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_kind_q   <= K_NORM;
      s2_ext_q    <= '0;
      s2_exp_q    <= '0;
      out_valid_q <= 1'b0;
      out_mode_q  <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_sign_q   <= s1_sign_d;
      s1_kind_q   <= s1_kind_d;
      s1_sig_q    <= s1_sig_d;
      s1_sh_q     <= s1_sh_d;
      s2_valid_q  <= s2_valid_d;
      s2_mode_q   <= s2_mode_d;
      s2_sign_q   <= s2_sign_d;
      s2_kind_q   <= s2_kind_d;
      s2_ext_q    <= s2_ext_d;
      s2_exp_q    <= s2_exp_d;
      out_valid_q <= out_valid_d;
      out_mode_q  <= out_mode_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_fp_fixed_convert_pipe.sv
// Self-checking bench for fp_fixed_convert_pipe (INT_W=8, FRAC_W=13): directed vectors,
// back-pressure, randomized traffic against a real-arithmetic reference model, mid-stream reset.
module tb_fp_fixed_convert_pipe;

  localparam int INT_W  = 8;
  localparam int FRAC_W = 13;
  localparam int W      = INT_W + FRAC_W;
  localparam logic [31:0] MAX_POS = 32'h000F_FFFF;
  localparam logic [31:0] MIN_NEG = 32'hFFF0_0000;
`ifdef CONV_ROUND_EN
  localparam logic [31:0] RND_EXP = 32'h0000_2002;
`else
  localparam logic [31:0] RND_EXP = 32'h0000_2001;
`endif

  logic        clk, reset_n, in_valid, in_ready, in_mode, out_valid, out_ready, out_mode, out_ovf;
  logic [31:0] in_data, out_data;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_out    = 0;
  logic [33:0] sb[$];
  logic [33:0] held, last_out;
  bit          stall_prev = 0;
  bit          last_acc, last_emit;

  fp_fixed_convert_pipe #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else repeat (-e) r = r / 2.0;
    return r;
  endfunction

  // Reference: {mode, ovf, data}
  function automatic logic [33:0] model_f2x(input logic [31:0] f);
    int  ex = int'(f[30:23]);
    real q, fl, fr;
    longint v;
    if (ex == 255) return (f[22:0] == 0) ? {2'b01, f[31] ? MIN_NEG : MAX_POS} : {2'b01, 32'h0};
    if (ex == 0) return '0;
    q  = (1.0 + real'(f[22:0]) / pow2(23)) * pow2(ex - 127 + FRAC_W);
    fl = $floor(q);
`ifdef CONV_ROUND_EN
    fr = q - fl;
    if (fr > 0.5 || (fr == 0.5 && (longint'(fl) % 2) == 1)) fl = fl + 1.0;
`else
    fr = 0.0;
`endif
    if (!f[31] && fl >= pow2(W - 1)) return {2'b01, MAX_POS};
    if (f[31] && fl > pow2(W - 1)) return {2'b01, MIN_NEG};
    v = longint'(fl + fr * 0.0);
    if (f[31]) v = -v;
    return {2'b00, 32'(v)};
  endfunction

  function automatic logic [33:0] model_x2f(input logic [31:0] d);
    longint v, mag, num, mant, rem;
    int p = 0;
    int ex;
    v = longint'(d[W-1:0]);
    if (d[W-1]) v = v - (longint'(1) << W);
    if (v == 0) return {2'b10, 32'h0};
    mag = (v < 0) ? -v : v;
    while ((longint'(1) << (p + 1)) <= mag) p++;
    ex   = 127 + p - FRAC_W;
    num  = (mag - (longint'(1) << p)) << 23;
    mant = num >> p;
    rem  = num - (mant << p);
`ifdef CONV_ROUND_EN
    if (2 * rem > (longint'(1) << p) || (2 * rem == (longint'(1) << p) && (mant % 2) == 1)) mant++;
    if (mant == (longint'(1) << 23)) begin mant = 0; ex++; end
`else
    rem = rem * 0;
`endif
    return {2'b10, v < 0, 8'(ex), 23'(mant)};
  endfunction

  // One clock: sample handshakes at negedge, score them, then step past the rising edge
  task automatic cycle();
    logic [33:0] obs, e;
    @(negedge clk);
    obs       = {out_mode, out_ovf, out_data};
    last_acc  = in_valid && in_ready;
    last_emit = out_valid && out_ready;
    if (stall_prev) check("stall_hold", obs, held);
    if (last_acc) sb.push_back(in_mode ? model_x2f(in_data) : model_f2x(in_data));
    if (out_valid) last_out = obs;
    if (last_emit) begin
      n_out++;
      check("sb_pending", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_result", obs, e);
      end
    end
    stall_prev = out_valid && !out_ready;
    held       = obs;
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input string tag, input logic m, input logic [31:0] d,
                      input logic [31:0] ed, input logic eo);
    int lat = 0;
    bit seen = 0;
    in_valid = 1; in_mode = m; in_data = d; out_ready = 1;
    cycle();
    check({tag, "_acc"}, 64'(last_acc), 64'd1);
    in_valid = 0;
    while (!seen && lat < 10) begin
      cycle();
      lat++;
      if (last_emit) seen = 1;
    end
    check({tag, "_lat"}, 64'(lat), 64'd3);
    check({tag, "_data"}, 64'(last_out[31:0]), 64'(ed));
    check({tag, "_ovf"}, 64'(last_out[32]), 64'(eo));
    check({tag, "_mode"}, 64'(last_out[33]), 64'(m));
  endtask

  task automatic backpressure();
    logic [31:0] items[5];
    logic        modes[5];
    int idx = 0, outs0 = n_out, blocked_at = -1;
    items[0] = 32'h3F80_0000; modes[0] = 0;
    items[1] = 32'h0000_6000; modes[1] = 1;
    items[2] = 32'hC020_0000; modes[2] = 0;
    items[3] = 32'h001F_F000; modes[3] = 1;
    items[4] = 32'h4348_0000; modes[4] = 0;
    for (int c = 0; c < 40 && (n_out - outs0) < 5; c++) begin
      in_valid  = (idx < 5);
      in_mode   = modes[idx % 5];
      in_data   = items[idx % 5];
      out_ready = (c >= 6);
      cycle();
      if (in_valid && !last_acc && blocked_at < 0) blocked_at = idx;
      if (last_acc) idx++;
    end
    in_valid = 0;
    check("bp_block_after", 64'(blocked_at), 64'd3);
    check("bp_out_count", 64'(n_out - outs0), 64'd5);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [31:0] rand_operand(input logic m);
    int sel = $urandom_range(0, 7);
    logic [31:0] r = $urandom;
    if (!m) begin
      if (sel == 0) return r;
      if (sel == 1) return {r[31], ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00, (r[0] ? 23'h0 : r[22:0])};
      return {r[31], 8'($urandom_range(110, 136)), r[22:0]};
    end
    if (sel == 0) return 32'h0;
    if (sel == 1) return 32'h0010_0000;
    return r;
  endfunction

  task automatic random_phase();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_mode   = 1'($urandom_range(0, 1));
      in_data   = rand_operand(in_mode);
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    in_valid = 0; out_ready = 1;
    for (int c = 0; c < 20 && sb.size() != 0; c++) cycle();
    check("rand_drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic reset_midflight();
    out_ready = 0; in_valid = 1; in_mode = 0;
    in_data = 32'h3F80_0000; cycle();
    in_data = 32'h4000_0000; cycle();
    in_valid = 0; cycle();
    check("mid_valid_before", 64'(out_valid), 64'd1);
    #2 reset_n = 0;
    #1;
    check("mid_valid_in_rst", 64'(out_valid), 64'd0);
    check("mid_data_in_rst", 64'(out_data), 64'd0);
    sb.delete();
    stall_prev = 0;
    @(posedge clk);
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;
    out_ready = 1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("mid_no_stale", 64'(out_valid), 64'd0);
    end
    xact("mid_new_item", 1, 32'h0000_6000, 32'h4040_0000, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 0; in_valid = 0; in_mode = 0; in_data = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_out_mode", 64'(out_mode), 64'd0);
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    xact("f2x_one",      0, 32'h3F80_0000, 32'h0000_2000, 0);
    xact("f2x_m2p5",     0, 32'hC020_0000, 32'hFFFF_B000, 0);
    xact("f2x_200",      0, 32'h4348_0000, 32'h000F_FFFF, 1);
    xact("f2x_ninf",     0, 32'hFF80_0000, 32'hFFF0_0000, 1);
    xact("f2x_nan",      0, 32'h7FC0_0000, 32'h0000_0000, 1);
    xact("f2x_m128",     0, 32'hC300_0000, 32'hFFF0_0000, 0);
    xact("f2x_p128",     0, 32'h4300_0000, 32'h000F_FFFF, 1);
    xact("f2x_lsb",      0, 32'h3900_0000, 32'h0000_0001, 0);
    xact("f2x_sub_lsb",  0, 32'h3880_0000, 32'h0000_0000, 0);
    xact("f2x_negzero",  0, 32'h8000_0000, 32'h0000_0000, 0);
    // 1 + 3*2^-14: exactly half an LSB above 0x2001
    xact("f2x_round",    0, 32'h3F80_0600, RND_EXP, 0);
    xact("x2f_three",    1, 32'h0000_6000, 32'h4040_0000, 0);
    xact("x2f_mhalf",    1, 32'h001F_F000, 32'hBF00_0000, 0);
    xact("x2f_m128",     1, 32'h0010_0000, 32'hC300_0000, 0);
    xact("x2f_zero",     1, 32'h0000_0000, 32'h0000_0000, 0);
    xact("x2f_max",      1, 32'h000F_FFFF, 32'h42FF_FFF0, 0);
    xact("x2f_lsb",      1, 32'h0000_0001, 32'h3900_0000, 0);
    xact("x2f_upper_ign",1, 32'hFFE0_6000, 32'h4040_0000, 0);

    backpressure();
    random_phase();
    reset_midflight();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
